// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle datapath controller: FSM states,
// decoded opcodes and ALU operation selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        TRAP      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle load/store/R-type/branch core,
// with stall freezing, sticky illegal-opcode trap and a retired-instruction counter.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             memReady,
    input  logic             stall,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             memToReg,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic             pcSource,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic             illegalInstr,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    state_t cur_state;
    state_t nxt_state;
    logic   armed;
    logic   retire;

    // IDLE waits for one full clock after reset release: the first edge
    // only arms, the second edge moves on to FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
            armed     <= 1'b0;
            instret   <= '0;
        end else if (!stall) begin
            cur_state <= nxt_state;
            if (cur_state == IDLE)
                armed <= 1'b1;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        retire = 1'b0;
        case (cur_state)
            MEM_WB, ALU_WB, BRANCH: retire = 1'b1;
            MEM_WRITE:              retire = memReady;
            default:                retire = 1'b0;
        endcase
    end

    always_comb begin
        nxt_state = cur_state;
        case (cur_state)
            IDLE:      nxt_state = armed ? FETCH : IDLE;
            FETCH:     if (memReady) nxt_state = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt_state = MEM_ADDR;
                    OP_RTYPE:          nxt_state = EXECUTE;
                    OP_BRANCH:         nxt_state = BRANCH;
                    default:           nxt_state = TRAP;
                endcase
            end
            MEM_ADDR:  nxt_state = (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (memReady) nxt_state = MEM_WB;
            MEM_WRITE: if (memReady) nxt_state = FETCH;
            MEM_WB:    nxt_state = FETCH;
            EXECUTE:   nxt_state = ALU_WB;
            ALU_WB:    nxt_state = FETCH;
            BRANCH:    nxt_state = FETCH;
            TRAP:      nxt_state = TRAP;
            default:   nxt_state = IDLE;
        endcase
    end

    always_comb begin
        pcWrite      = 1'b0;
        pcWriteCond  = 1'b0;
        iorD         = 1'b0;
        memRead      = 1'b0;
        memWrite     = 1'b0;
        irWrite      = 1'b0;
        memToReg     = 1'b0;
        regWrite     = 1'b0;
        aluSrcA      = 1'b0;
        pcSource     = 1'b0;
        aluSrcB      = 2'b00;
        aluOp        = ALUOP_ADD;
        illegalInstr = 1'b0;
        case (cur_state)
            FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            DECODE:    aluSrcB = 2'b11;
            MEM_ADDR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
            end
            ALU_WB:    regWrite = 1'b1;
            BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALUOP_SUB;
                pcWriteCond = 1'b1;
                pcSource    = 1'b1;
            end
            TRAP:      illegalInstr = 1'b1;
            default: ;
        endcase
        // A stalled cycle must not commit anything, whatever the state.
        if (stall) begin
            pcWrite     = 1'b0;
            pcWriteCond = 1'b0;
            irWrite     = 1'b0;
            regWrite    = 1'b0;
            memWrite    = 1'b0;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams checked against a per-instruction phase model.
module tb_multicycle_control;
    import ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic       memReady;
    logic       stall;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regWrite, aluSrcA, pcSource, illegalInstr;
    logic [1:0] aluSrcB, aluOp;
    logic [3:0] instret;
    logic [3:0] state;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned retired = 0;

    multicycle_control #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .memReady(memReady), .stall(stall),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .pcSource(pcSource), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .illegalInstr(illegalInstr), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    logic [14:0] obs_out;
    assign obs_out = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                      regWrite, aluSrcA, pcSource, aluSrcB, aluOp, illegalInstr};

    // Control table for each phase; write enables are dropped on a stalled cycle.
    function automatic logic [14:0] exp_out(state_t p, logic rdy, logic stl);
        logic pw, pwc, iord, mr, mw, irw, m2r, rw, asa, ps, ill;
        logic [1:0] asb, aop;
        {pw, pwc, iord, mr, mw, irw, m2r, rw, asa, ps, ill} = '0;
        asb = 2'b00;
        aop = 2'b00;
        if (p == FETCH)     begin mr = 1; asb = 2'b01; irw = rdy; pw = rdy; end
        if (p == DECODE)    asb = 2'b11;
        if (p == MEM_ADDR)  begin asa = 1; asb = 2'b10; end
        if (p == MEM_READ)  begin mr = 1; iord = 1; end
        if (p == MEM_WB)    begin rw = 1; m2r = 1; end
        if (p == MEM_WRITE) begin mw = 1; iord = 1; end
        if (p == EXECUTE)   begin asa = 1; aop = 2'b10; end
        if (p == ALU_WB)    rw = 1;
        if (p == BRANCH)    begin asa = 1; aop = 2'b01; pwc = 1; ps = 1; end
        if (p == TRAP)      ill = 1;
        if (stl) {pw, pwc, irw, rw, mw} = '0;
        return {pw, pwc, iord, mr, mw, irw, m2r, rw, asa, ps, asb, aop, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle spent in phase p with the given inputs.
    task automatic step(input state_t p, input logic rdy, input logic stl);
        memReady = rdy;
        stall    = stl;
        #1;
        chk($sformatf("state@%s", p.name()), 32'(state), 32'(p));
        chk($sformatf("outs@%s", p.name()), 32'(obs_out), 32'(exp_out(p, rdy, stl)));
        chk("instret", 32'(instret), retired % 16);
        @(posedge clk);
        #1;
    endtask

    task automatic phase(input state_t p, input bit mem, input int unsigned stalls,
                         input int unsigned waits, input bit rnd_rdy);
        for (int unsigned i = 0; i < stalls; i++)
            step(p, rnd_rdy ? 1'($urandom % 2) : 1'b1, 1'b1);
        if (mem)
            for (int unsigned i = 0; i < waits; i++)
                step(p, 1'b0, 1'b0);
        step(p, mem ? 1'b1 : 1'($urandom % 2), 1'b0);
    endtask

    function automatic int unsigned pick(input bit rnd, input int unsigned hi);
        return rnd ? $urandom_range(0, hi) : 0;
    endfunction

    task automatic run_instr(input logic [6:0] op, input bit rnd,
                             input int unsigned mstall, input int unsigned mwait);
        opcode = op;
        phase(FETCH, 1, pick(rnd, 2), pick(rnd, 2), rnd);
        phase(DECODE, 0, pick(rnd, 1), 0, rnd);
        if (op == OP_LOAD) begin
            phase(MEM_ADDR, 0, pick(rnd, 1), 0, rnd);
            phase(MEM_READ, 1, mstall, mwait, rnd);
            phase(MEM_WB, 0, pick(rnd, 1), 0, rnd);
        end else if (op == OP_STORE) begin
            phase(MEM_ADDR, 0, pick(rnd, 1), 0, rnd);
            phase(MEM_WRITE, 1, mstall, mwait, rnd);
        end else if (op == OP_RTYPE) begin
            phase(EXECUTE, 0, pick(rnd, 1), 0, rnd);
            phase(ALU_WB, 0, pick(rnd, 1), 0, rnd);
        end else begin
            phase(BRANCH, 0, pick(rnd, 1), 0, rnd);
        end
        retired++;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(state), 32'(IDLE));
        chk({tag, "_outs"}, 32'(obs_out), 32'd0);
        chk({tag, "_instret"}, 32'(instret), 32'd0);
    endtask

    initial begin
        logic [6:0] ops [4];
        ops[0] = OP_LOAD;
        ops[1] = OP_STORE;
        ops[2] = OP_RTYPE;
        ops[3] = OP_BRANCH;

        rst = 1'b1;
        opcode = OP_RTYPE;
        memReady = 1'b0;
        stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        step(IDLE, 1'b1, 1'b0);
        step(IDLE, 1'b1, 1'b0);

        // Directed: R-type, lw with three wait states, sw stalled with ready, beq.
        run_instr(OP_RTYPE, 0, 0, 0);
        run_instr(OP_LOAD, 0, 0, 3);
        run_instr(OP_STORE, 0, 2, 0);
        run_instr(OP_BRANCH, 0, 0, 0);

        for (int unsigned n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 3)], 1, $urandom_range(0, 2), $urandom_range(0, 3));

        // Sixteen branches pass the counter through its wrap point.
        for (int unsigned n = 0; n < 16; n++)
            run_instr(OP_BRANCH, 0, 0, 0);

        // Asynchronous reset landing in the middle of EXECUTE.
        opcode = OP_RTYPE;
        step(FETCH, 1'b1, 1'b0);
        step(DECODE, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        retired = 0;
        check_reset_outputs("async_rst");
        #2;
        rst = 1'b0;
        step(IDLE, 1'b1, 1'b0);
        step(IDLE, 1'b1, 1'b0);
        run_instr(OP_RTYPE, 0, 0, 0);

        // Illegal opcode: trap persists, counter frozen, only reset leaves it.
        opcode = 7'b1111111;
        step(FETCH, 1'b1, 1'b0);
        step(DECODE, 1'b0, 1'b0);
        for (int unsigned n = 0; n < 10; n++)
            step(TRAP, 1'($urandom % 2), 1'($urandom % 2));
        #2;
        rst = 1'b1;
        #1;
        retired = 0;
        check_reset_outputs("trap_rst");
        #2;
        rst = 1'b0;
        step(IDLE, 1'b0, 1'b0);
        step(IDLE, 1'b0, 1'b0);
        run_instr(OP_LOAD, 0, 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the retired-instruction counter width.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port opcode, input, 7 bits: instruction[6:0] from the instruction register.
REQ-005 SHALL have port memReady, input, 1 bit: the memory access in progress completes this cycle.
REQ-006 SHALL have port stall, input, 1 bit: freeze the FSM and suppress all write enables.
REQ-007 SHALL have 1-bit outputs pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regWrite, aluSrcA and pcSource.
REQ-008 SHALL have 2-bit outputs aluSrcB and aluOp; aluOp drives the aluOp input of the ALU control decoder.
REQ-009 SHALL have output illegalInstr, 1 bit: sticky flag for an unsupported opcode.
REQ-010 SHALL have output instret, CNT_W bits: retired-instruction count.
REQ-011 SHALL have output state, 4 bits: current FSM state, for debug.

Function
REQ-012 SHALL implement the states IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH and TRAP.
REQ-013 SHALL decode all control outputs combinationally from the state register (Moore); every output not listed for a state SHALL be 0.
REQ-014 SHALL drive these outputs per state:
- IDLE: none asserted.
- FETCH: memRead=1, aluSrcB=01, aluOp=00; irWrite=memReady, pcWrite=memReady.
- DECODE: aluSrcB=11, aluOp=00.
- MEM_ADDR: aluSrcA=1, aluSrcB=10, aluOp=00.
- MEM_READ: memRead=1, iorD=1.
- MEM_WB: regWrite=1, memToReg=1.
- MEM_WRITE: memWrite=1, iorD=1.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10.
- ALU_WB: regWrite=1.
- BRANCH: aluSrcA=1, aluOp=01, pcWriteCond=1, pcSource=1.
- TRAP: illegalInstr=1.
REQ-015 SHALL sequence transitions as follows:
- IDLE goes to FETCH.
- FETCH goes to DECODE when memReady=1, else holds.
- DECODE goes by opcode: 0000011 or 0100011 to MEM_ADDR; 0110011 to EXECUTE; 1100011 to BRANCH; any other value to TRAP.
REQ-016 SHALL take MEM_ADDR to MEM_READ for opcode 0000011 and to MEM_WRITE for opcode 0100011.
REQ-017 SHALL hold MEM_READ until memReady=1, then go to MEM_WB; MEM_WRITE SHALL hold until memReady=1, then go to FETCH.
REQ-018 SHALL take MEM_WB, ALU_WB and BRANCH to FETCH, and EXECUTE to ALU_WB.
REQ-019 SHALL hold TRAP until reset.
REQ-020 SHALL keep every output stable for the whole of a memReady wait.
REQ-021 SHALL, while stall=1, hold the state and force pcWrite, pcWriteCond, irWrite, regWrite and memWrite to 0; other outputs SHALL still follow the state.
REQ-022 SHALL let stall win when stall=1 and memReady=1 coincide: no transition and no write that cycle.
REQ-023 SHALL require opcode to be stable from DECODE through retirement; the block SHALL NOT latch it.
REQ-024 SHALL increment instret by 1 on each retire edge, modulo 2^CNT_W, wrapping from all-ones to 0.
REQ-025 SHALL define a retire edge as the clock edge leaving MEM_WB, ALU_WB or BRANCH, or leaving MEM_WRITE with memReady=1.
REQ-026 SHALL NOT count an instruction that ends in TRAP.
REQ-027 SHALL fix instruction latency, with zero memory wait states, at: R-type 4 cycles, lw 5, sw 4, beq 3, counted from entering FETCH.

Reset
REQ-028 SHALL, on rst asserted, immediately set state=IDLE, instret=0 and illegalInstr=0, leaving all control outputs 0.
REQ-029 SHALL let reset asserted in any state, including a memReady wait or TRAP, abort the operation with no write enable asserted afterwards.
REQ-030 SHALL, after rst deasserts, spend one cycle in IDLE and then enter FETCH.

Structure
REQ-031 SHALL place in the shared package ctrl_pkg: the state enum; opcode constants OP_LOAD, OP_STORE, OP_RTYPE and OP_BRANCH; aluOp constants ALUOP_ADD=00, ALUOP_SUB=01 and ALUOP_FUNCT=10.
REQ-032 SHALL be a single module, with no sub-module.

Verification
REQ-033 SHALL pass the R-type scenario: after reset, opcode=0110011, memReady=1 -> FETCH, DECODE, EXECUTE(aluOp=10), ALU_WB(regWrite=1), FETCH; instret=1.
REQ-034 SHALL pass the lw wait-state scenario: opcode=0000011, memReady=0 for 3 cycles in MEM_READ -> memRead=1 and iorD=1 held 4 cycles, then MEM_WB with regWrite=1 and memToReg=1; instret+1.
REQ-035 SHALL pass the sw-with-stall scenario: opcode=0100011, stall=1 and memReady=1 in MEM_WRITE for 2 cycles -> state holds, memWrite=0; stall=0 -> memWrite=1 for one cycle, then FETCH.
REQ-036 SHALL pass the illegal-opcode scenario: opcode=1111111 in DECODE -> TRAP, illegalInstr=1 held for 10 cycles, instret unchanged.
REQ-037 SHALL pass the counter-wrap scenario: CNT_W=4, 16 beq instructions -> instret goes 15 then 0; each BRANCH shows pcWriteCond=1 and aluOp=01.
REQ-038 SHALL pass the async-reset scenario: rst pulsed mid-cycle in EXECUTE -> state=IDLE and outputs 0 before the next clock edge, then FETCH two edges after release.
